// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_pkg;

    localparam int OP_W    = 16;   // operand width
    localparam int PROD_W  = 32;   // full product / accumulator width
    localparam int HALF_W  = 8;    // width of one operand slice fed to the 8x8 core
    localparam int N_STEPS = 4;    // partial products per operation
    localparam int STEP_W  = 3;    // step counter must also hold N_STEPS (issue finished)
    localparam int CNT_W   = 16;   // done counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One partial product travelling through the optional product register stages,
    // tagged with its step index so the accumulator knows where to place it.
    typedef struct packed {
        logic                  vld;
        logic [1:0]            k;
        logic [2*HALF_W-1:0]   p;
    } pstage_t;

    // Step k selects a-half = k[0], b-half = k[1]; the weight is the sum of the half indices.
    function automatic logic [4:0] step_shift(input logic [1:0] k);
        case (k)
            2'd0:    step_shift = 5'd0;
            2'd3:    step_shift = 5'd16;
            default: step_shift = 5'd8;
        endcase
    endfunction

endpackage

// File: rtl/dadda_mult_8x8.sv
// Unsigned 8x8 -> 16 combinational multiplier core (shift-and-add partial products).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: a, b = unsigned operands; p = exact product a*b.
module dadda_mult_8x8
    import mult_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    // Partial-product rows summed; synthesis is free to reduce them as a compressor tree.
    always_comb begin
        p = '0;
        for (int i = 0; i < HALF_W; i++) begin
            if (b[i]) begin
                p = p + ((2*HALF_W)'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier time-sharing one 8x8 core over four steps.
// Latency: 4+MUL_LAT cycles from accept edge to out_valid.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk/rst_n (async active-low), clr (sync abort), in_valid/in_ready/in_a/in_b
//        operand handshake, out_valid/out_ready/out_p product handshake,
//        busy (not IDLE), done_cnt (products consumed, wraps).
// MUL_LAT: register stages after the 8x8 product, legal range 0..2.
module mult16_seq_ctrl
    import mult_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    state_t              state_q, state_d;
    logic                init_q;      // low until the first edge after reset release
    logic [OP_W-1:0]     a_q, b_q;
    logic [STEP_W-1:0]   step_q;      // next step to issue; N_STEPS means all issued
    logic [PROD_W-1:0]   acc_q;
    logic                accept, consume, issue;
    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [2*HALF_W-1:0] mul_p;
    pstage_t             stg0, tail;

    // ---------------------------------------------------------------
    // Operand slice selection and the single shared 8x8 core
    // ---------------------------------------------------------------
    assign issue = (state_q == MUL) && (step_q < STEP_W'(N_STEPS));
    assign mul_a = step_q[0] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign mul_b = step_q[1] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];

    dadda_mult_8x8 u_core (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        stg0     = '0;
        stg0.vld = issue;
        stg0.k   = step_q[1:0];
        stg0.p   = mul_p;
    end

    // ---------------------------------------------------------------
    // Optional product register stages; each entry carries its step tag
    // ---------------------------------------------------------------
    generate
        if (MUL_LAT == 0) begin : g_no_pipe
            assign tail = stg0;
        end else begin : g_pipe
            pstage_t pipe_q [MUL_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= stg0;
                    for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign tail = pipe_q[MUL_LAT-1];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        consume   = 1'b0;
        in_ready  = (state_q == IDLE) && init_q;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid && init_q) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                // The last step's product lands in the accumulator on this same edge.
                if (tail.vld && (tail.k == 2'd3)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    consume = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake in the same cycle.
        if (clr) begin
            state_d = IDLE;
            accept  = 1'b0;
            consume = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Datapath: operand capture, step counter, accumulator
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            step_q <= '0;
            acc_q  <= '0;
        end else begin
            init_q <= 1'b1;
            if (clr) begin
                step_q <= '0;
                acc_q  <= '0;
            end else if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                step_q <= '0;
                acc_q  <= '0;
            end else begin
                if (issue)    step_q <= step_q + STEP_W'(1);
                // Max sum is (2^16-1)^2 < 2^32, so the adds never overflow.
                if (tail.vld) acc_q  <= acc_q + (PROD_W'(tail.p) << step_shift(tail.k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       done_cnt <= '0;
        else if (consume) done_cnt <= done_cnt + CNT_W'(1);
    end

    assign out_p = acc_q;

endmodule
